// File: rtl/cnt_mode_ctrl_pkg.sv
// Shared encodings for the key-count mode controller: modes, key events, blank bits.
package cnt_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_EDIT_H = 2'd1,
        MODE_EDIT_T = 2'd2,
        MODE_EDIT_O = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_K1    = 2'd1,
        EV_K2    = 2'd2,
        EV_CHORD = 2'd3
    } ev_e;

    localparam logic [2:0] BLANK_LOW = 3'b111;

    // Digits are summed at 10 bits so an out-of-range edit saturates instead of wrapping.
    function automatic logic [7:0] f_clamp_digits(input logic [3:0] h, input logic [3:0] t,
                                                  input logic [3:0] o, input logic [7:0] vmax);
        logic [9:0] sum;
        sum = 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
        return (sum > 10'(vmax)) ? vmax : sum[7:0];
    endfunction

endpackage

// File: rtl/cnt_mode_ctrl_if.sv
// Key-flag inputs and display-path outputs of the mode controller.
interface cnt_mode_ctrl_if;
    logic       flag1;
    logic       flag2;
    logic [7:0] data_bin;
    logic [5:0] blank;
    logic [1:0] mode;

    modport master (output flag1, flag2, input data_bin, blank, mode);
    modport slave  (input flag1, flag2, output data_bin, blank, mode);
endinterface

// File: rtl/cnt_key_chord.sv
// Key decoder: pairs key flags arriving within WIN cycles into a chord, else emits single events.
module cnt_key_chord
    import cnt_mode_ctrl_pkg::*;
#(
    parameter int WIN = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flag1,
    input  logic i_flag2,
    output ev_e  o_ev
);
    localparam int TW = $clog2(WIN);

    typedef enum logic [1:0] {PEND_NONE, PEND_K1, PEND_K2} pend_e;

    pend_e         r_pend, w_pend_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    ev_e           r_ev, w_ev_nxt;
    ev_e           w_single;
    logic          w_same;

    assign w_single = (r_pend == PEND_K1) ? EV_K1 : EV_K2;
    assign w_same   = (r_pend == PEND_K1) ? i_flag1 : i_flag2;

    // The event is registered one cycle after the timer hits WIN-2, so it lands WIN cycles after the press.
    always_comb begin
        w_pend_nxt  = r_pend;
        w_timer_nxt = r_timer;
        w_ev_nxt    = EV_NONE;
        if (i_flag1 && i_flag2) begin
            w_ev_nxt    = EV_CHORD;
            w_pend_nxt  = PEND_NONE;
            w_timer_nxt = '0;
        end else if (r_pend == PEND_NONE) begin
            if (i_flag1 || i_flag2) begin
                w_pend_nxt  = i_flag1 ? PEND_K1 : PEND_K2;
                w_timer_nxt = '0;
            end
        end else if (w_same) begin
            w_ev_nxt    = w_single;
            w_timer_nxt = '0;
        end else if (i_flag1 || i_flag2) begin
            w_ev_nxt    = EV_CHORD;
            w_pend_nxt  = PEND_NONE;
            w_timer_nxt = '0;
        end else if (r_timer == TW'(WIN - 2)) begin
            w_ev_nxt    = w_single;
            w_pend_nxt  = PEND_NONE;
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= PEND_NONE;
            r_timer <= '0;
            r_ev    <= EV_NONE;
        end else begin
            r_pend  <= w_pend_nxt;
            r_timer <= w_timer_nxt;
            r_ev    <= w_ev_nxt;
        end
    end

    assign o_ev = r_ev;

endmodule

// File: rtl/cnt_mode_ctrl.sv
// Key-count mode controller: RUN up/down counting plus per-digit EDIT modes with blink.
// state  | meaning
// RUN    | K1/K2 count data_bin up/down with wrap, chord loads digits
// EDIT_H | K1/K2 step hundreds digit, hundreds blinks
// EDIT_T | K1/K2 step tens digit, tens blinks
// EDIT_O | K1/K2 step ones digit, next chord returns to RUN
module cnt_mode_ctrl
    import cnt_mode_ctrl_pkg::*;
#(
    parameter int WIN   = 1_000_000,
    parameter int BLINK = 12_500_000,
    parameter int MAX   = 255
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cnt_mode_ctrl_if.slave bus
);
    localparam int         BW    = $clog2(BLINK);
    localparam logic [7:0] V_MAX = 8'(MAX);
    localparam logic [3:0] H_MAX = 4'(MAX / 100);

    ev_e           w_ev;
    mode_e         r_mode, w_mode_nxt;
    logic [7:0]    r_value, w_value_nxt;
    logic [3:0]    r_h, r_t, r_o, w_h_nxt, w_t_nxt, w_o_nxt;
    logic [BW-1:0] r_blink_cnt, w_blink_nxt;
    logic          r_phase, w_phase_nxt;
    logic [5:0]    w_blank;

    cnt_key_chord #(.WIN(WIN)) u_key_chord (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flag1 (bus.flag1),
        .i_flag2 (bus.flag2),
        .o_ev    (w_ev)
    );

    always_comb begin
        w_mode_nxt  = r_mode;
        w_value_nxt = r_value;
        w_h_nxt     = r_h;
        w_t_nxt     = r_t;
        w_o_nxt     = r_o;
        w_blink_nxt = r_blink_cnt;
        w_phase_nxt = r_phase;

        case (r_mode)
            MODE_RUN: begin
                case (w_ev)
                    EV_K1:    w_value_nxt = (r_value == V_MAX) ? 8'd0 : r_value + 8'd1;
                    EV_K2:    w_value_nxt = (r_value == 8'd0) ? V_MAX : r_value - 8'd1;
                    EV_CHORD: begin
                        w_mode_nxt = MODE_EDIT_H;
                        w_h_nxt    = 4'(r_value / 8'd100);
                        w_t_nxt    = 4'((r_value % 8'd100) / 8'd10);
                        w_o_nxt    = 4'(r_value % 8'd10);
                    end
                    default: ;
                endcase
            end
            MODE_EDIT_H: begin
                case (w_ev)
                    EV_K1:    w_h_nxt = (r_h == H_MAX) ? 4'd0 : r_h + 4'd1;
                    EV_K2:    w_h_nxt = (r_h == 4'd0) ? H_MAX : r_h - 4'd1;
                    EV_CHORD: w_mode_nxt = MODE_EDIT_T;
                    default: ;
                endcase
            end
            MODE_EDIT_T: begin
                case (w_ev)
                    EV_K1:    w_t_nxt = (r_t == 4'd9) ? 4'd0 : r_t + 4'd1;
                    EV_K2:    w_t_nxt = (r_t == 4'd0) ? 4'd9 : r_t - 4'd1;
                    EV_CHORD: w_mode_nxt = MODE_EDIT_O;
                    default: ;
                endcase
            end
            MODE_EDIT_O: begin
                case (w_ev)
                    EV_K1:    w_o_nxt = (r_o == 4'd9) ? 4'd0 : r_o + 4'd1;
                    EV_K2:    w_o_nxt = (r_o == 4'd0) ? 4'd9 : r_o - 4'd1;
                    EV_CHORD: w_mode_nxt = MODE_RUN;
                    default: ;
                endcase
            end
            default: ;
        endcase

        if (r_mode != MODE_RUN) begin
            w_value_nxt = f_clamp_digits(w_h_nxt, w_t_nxt, w_o_nxt, V_MAX);
            if (r_blink_cnt == BW'(BLINK - 1)) begin
                w_blink_nxt = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_blink_nxt = r_blink_cnt + BW'(1);
            end
        end

        // Any mode change or digit step restarts the blink with the digit lit.
        if ((w_mode_nxt != r_mode) || ((r_mode != MODE_RUN) && (w_ev == EV_K1 || w_ev == EV_K2))) begin
            w_blink_nxt = '0;
            w_phase_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode      <= MODE_RUN;
            r_value     <= 8'd0;
            r_h         <= 4'd0;
            r_t         <= 4'd0;
            r_o         <= 4'd0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_value     <= w_value_nxt;
            r_h         <= w_h_nxt;
            r_t         <= w_t_nxt;
            r_o         <= w_o_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    always_comb begin
        w_blank = {3'b000, BLANK_LOW};
        case (r_mode)
            MODE_EDIT_H: w_blank[5] = r_phase;
            MODE_EDIT_T: w_blank[4] = r_phase;
            MODE_EDIT_O: w_blank[3] = r_phase;
            default: ;
        endcase
    end

    assign bus.data_bin = r_value;
    assign bus.mode     = r_mode;
    assign bus.blank    = w_blank;

endmodule

// File: tb/tb_cnt_mode_ctrl.sv
// Bench for cnt_mode_ctrl: expectations are queued as stimulus is driven and checked at their due cycle.
module tb_cnt_mode_ctrl;
    localparam int WIN   = 4;
    localparam int BLINK = 8;
    localparam int MAX   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic [1:0] mode;
        logic [5:0] blank;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    cnt_mode_ctrl_if bus();

    cnt_mode_ctrl #(.WIN(WIN), .BLINK(BLINK), .MAX(MAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse(input logic f1, input logic f2);
        bus.flag1 = f1;
        bus.flag2 = f2;
        tick();
        bus.flag1 = 1'b0;
        bus.flag2 = 1'b0;
    endtask

    function automatic exp_t mk(input int due, input logic [7:0] d, input logic [1:0] m,
                                input logic [5:0] b, input string tag);
        exp_t e;
        e.due = due;
        e.data = d;
        e.mode = m;
        e.blank = b;
        e.tag = tag;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        bus.flag1 = 1'b0;
        bus.flag2 = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
        exp_q.push_back(mk(0, 8'd0, 2'd0, 6'b000111, "reset"));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            while (cyc < e.due) tick();
            n_vec++;
            if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                n_err++;
                $display("FAIL %s cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                         e.tag, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
            end
        end
    endtask

    task automatic test_single_wrap();
        exp_t e;
        logic [7:0] model = 8'd0;
        for (int i = 0; i < 256; i++) begin
            int t;
            t = 10 + 10 * i;
            while (cyc < t) tick();
            exp_q.push_back(mk(t + WIN, model, 2'd0, 6'b000111, "single_hold"));
            model = (model == 8'(MAX)) ? 8'd0 : model + 8'd1;
            exp_q.push_back(mk(t + WIN + 1, model, 2'd0, 6'b000111, "single_up"));
            pulse(1'b1, 1'b0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                while (cyc < e.due) tick();
                n_vec++;
                if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                    n_err++;
                    $display("FAIL %s cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                             e.tag, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
                end
            end
        end
    endtask

    task automatic test_decrement_wrap();
        exp_t e;
        int t;
        t = cyc;
        exp_q.push_back(mk(t + 4, 8'd0, 2'd0, 6'b000111, "dec_hold"));
        exp_q.push_back(mk(t + 5, 8'd255, 2'd0, 6'b000111, "dec_wrap"));
        pulse(1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            while (cyc < e.due) tick();
            n_vec++;
            if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                n_err++;
                $display("FAIL %s cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                         e.tag, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
            end
        end
    endtask

    // Leaves the DUT in EDIT_H showing 155 with digits 1,5,5.
    task automatic test_chord_blink();
        exp_t e;
        int t;
        t = cyc;
        exp_q.push_back(mk(t + 3,  8'd255, 2'd0, 6'b000111, "chord_pre"));
        exp_q.push_back(mk(t + 4,  8'd255, 2'd1, 6'b000111, "chord_enter"));
        exp_q.push_back(mk(t + 11, 8'd255, 2'd1, 6'b000111, "blink_lit"));
        exp_q.push_back(mk(t + 12, 8'd255, 2'd1, 6'b100111, "blink_dark"));
        exp_q.push_back(mk(t + 19, 8'd255, 2'd1, 6'b100111, "blink_dark_end"));
        exp_q.push_back(mk(t + 20, 8'd255, 2'd1, 6'b000111, "blink_lit2"));
        exp_q.push_back(mk(t + 28, 8'd255, 2'd1, 6'b100111, "blink_dark2"));
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b1);
        exp_q.push_back(mk(t + 33, 8'd155, 2'd1, 6'b000111, "blink_clear"));
        exp_q.push_back(mk(t + 40, 8'd155, 2'd1, 6'b000111, "blink_clear_lit"));
        exp_q.push_back(mk(t + 41, 8'd155, 2'd1, 6'b100111, "blink_clear_dark"));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            while (cyc < e.due) tick();
            n_vec++;
            if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                n_err++;
                $display("FAIL %s cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                         e.tag, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
            end
            if (cyc == t + 28 && exp_q.size() == 3) pulse(1'b0, 1'b1);
        end
    endtask

    // Rows: {flag1, flag2, expected mode, expected data_bin}; chords apply after 2 cycles, singles after 5.
    task automatic test_digit_edit();
        exp_t e;
        logic [11:0] rows [17] = '{
            {1'b1, 1'b1, 2'd2, 8'd155}, {1'b0, 1'b1, 2'd2, 8'd145}, {1'b0, 1'b1, 2'd2, 8'd135},
            {1'b0, 1'b1, 2'd2, 8'd125}, {1'b1, 1'b1, 2'd3, 8'd125}, {1'b0, 1'b1, 2'd3, 8'd124},
            {1'b0, 1'b1, 2'd3, 8'd123}, {1'b1, 1'b1, 2'd0, 8'd123}, {1'b1, 1'b1, 2'd1, 8'd123},
            {1'b1, 1'b0, 2'd1, 8'd223}, {1'b1, 1'b0, 2'd1, 8'd23},  {1'b1, 1'b1, 2'd2, 8'd23},
            {1'b0, 1'b1, 2'd2, 8'd13},  {1'b0, 1'b1, 2'd2, 8'd3},   {1'b0, 1'b1, 2'd2, 8'd93},
            {1'b1, 1'b1, 2'd3, 8'd93},  {1'b1, 1'b1, 2'd0, 8'd93}
        };
        foreach (rows[i]) begin
            int t;
            int lat;
            t = cyc;
            lat = (rows[i][11] && rows[i][10]) ? 2 : WIN + 1;
            exp_q.push_back(mk(t + lat, rows[i][7:0], rows[i][9:8], 6'b000111, "digit_edit"));
            pulse(rows[i][11], rows[i][10]);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                while (cyc < e.due) tick();
                n_vec++;
                if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                    n_err++;
                    $display("FAIL %s row %0d cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                             e.tag, i, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
                end
            end
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        logic [11:0] rows [18] = '{
            {1'b1, 1'b1, 2'd1, 8'd93},  {1'b1, 1'b0, 2'd1, 8'd193}, {1'b1, 1'b0, 2'd1, 8'd255},
            {1'b1, 1'b1, 2'd2, 8'd255}, {1'b0, 1'b1, 2'd2, 8'd255}, {1'b0, 1'b1, 2'd2, 8'd255},
            {1'b0, 1'b1, 2'd2, 8'd255}, {1'b0, 1'b1, 2'd2, 8'd253}, {1'b1, 1'b1, 2'd3, 8'd253},
            {1'b0, 1'b1, 2'd3, 8'd252}, {1'b0, 1'b1, 2'd3, 8'd251}, {1'b0, 1'b1, 2'd3, 8'd250},
            {1'b1, 1'b1, 2'd0, 8'd250}, {1'b1, 1'b1, 2'd1, 8'd250}, {1'b1, 1'b1, 2'd2, 8'd250},
            {1'b1, 1'b0, 2'd2, 8'd255}, {1'b1, 1'b1, 2'd3, 8'd255}, {1'b1, 1'b1, 2'd0, 8'd255}
        };
        foreach (rows[i]) begin
            int t;
            int lat;
            t = cyc;
            lat = (rows[i][11] && rows[i][10]) ? 2 : WIN + 1;
            exp_q.push_back(mk(t + lat, rows[i][7:0], rows[i][9:8], 6'b000111, "clamp"));
            pulse(rows[i][11], rows[i][10]);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                while (cyc < e.due) tick();
                n_vec++;
                if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                    n_err++;
                    $display("FAIL %s row %0d cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                             e.tag, i, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
                end
            end
        end
    endtask

    task automatic test_repeat_reset();
        exp_t e;
        int t;
        t = cyc;
        exp_q.push_back(mk(t + 3, 8'd255, 2'd0, 6'b000111, "repeat_pre"));
        exp_q.push_back(mk(t + 4, 8'd0,   2'd0, 6'b000111, "repeat_first"));
        exp_q.push_back(mk(t + 6, 8'd0,   2'd0, 6'b000111, "repeat_hold"));
        exp_q.push_back(mk(t + 7, 8'd1,   2'd0, 6'b000111, "repeat_second"));
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b1, 1'b0);
        t = cyc - 3;
        exp_q.push_back(mk(t + 9,  8'd1, 2'd1, 6'b000111, "rst_edit_h"));
        exp_q.push_back(mk(t + 11, 8'd1, 2'd2, 6'b000111, "rst_edit_t"));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            while (cyc < e.due) tick();
            n_vec++;
            if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                n_err++;
                $display("FAIL %s cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                         e.tag, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
            end
            if (cyc == t + 7 || cyc == t + 9) pulse(1'b1, 1'b1);
        end
        // A pending key is left in the decoder when reset hits; it must not surface afterwards.
        pulse(1'b1, 1'b0);
        t = cyc;
        exp_q.push_back(mk(t + 1, 8'd0, 2'd0, 6'b000111, "rst_state"));
        exp_q.push_back(mk(t + 4, 8'd0, 2'd0, 6'b000111, "rst_no_event"));
        exp_q.push_back(mk(t + 8, 8'd0, 2'd0, 6'b000111, "rst_quiet"));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            while (cyc < e.due) tick();
            n_vec++;
            if (bus.data_bin !== e.data || bus.mode !== e.mode || bus.blank !== e.blank) begin
                n_err++;
                $display("FAIL %s cyc %0d: got data_bin=%0d mode=%0d blank=%b, expected %0d/%0d/%b",
                         e.tag, cyc, bus.data_bin, bus.mode, bus.blank, e.data, e.mode, e.blank);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_wrap();
        test_decrement_wrap();
        test_chord_blink();
        test_digit_edit();
        test_clamp();
        test_repeat_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
